// File: rtl/syscall_unit.sv
// -----------------------------------------------------------------------------
// syscall_unit
//   Synthesizable syscall dispatcher. It takes a syscall pulse plus packed
//   argument registers from the cpu, decodes the code and sequences the side
//   effects as multi-cycle transactions. Those side effects are memory
//   write/read-back, the console stream, video strobes, trig lookup and halt.
//
// Ports
//   clk, clear         clock, synchronous active-high reset
//   sys_signal         syscall request (rising edge detected internally)
//   sysregs            {arg1, arg0, code}, each DATA_W wide
//   busy, halt         servicing status, sticky halt (code 0)
//   mem_*              memory port: addr, wdata, we/re strobes, rdata (1-cycle)
//   load_signal/data   one-cycle value return to the cpu
//   trig_addr/rdata    trig table port (sin/cos pairs, 1-cycle latency)
//   con_*              console valid/ready stream, con_is_num selects decimal
//   vid_*              video activate/clear/write strobes with cell addr/data
//
// Build option
//   SYSCALL_STRLEN_LIMIT_EN : string print (code 5) stops after MAX_STR chars.
// -----------------------------------------------------------------------------
module syscall_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TRIG_AW = 10,
    parameter int unsigned MAX_STR = 256
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  sys_signal,
    input  logic [3*DATA_W-1:0]   sysregs,
    output logic                  busy,
    output logic                  halt,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  load_signal,
    output logic [DATA_W-1:0]     load_data,
    output logic [TRIG_AW-1:0]    trig_addr,
    input  logic [DATA_W-1:0]     trig_rdata,
    output logic                  con_valid,
    input  logic                  con_ready,
    output logic [DATA_W-1:0]     con_data,
    output logic                  con_is_num,
    output logic                  vid_activate,
    output logic                  vid_clear,
    output logic                  vid_write,
    output logic [DATA_W-1:0]     vid_addr,
    output logic [DATA_W-1:0]     vid_data
);

    typedef enum logic [3:0] {
        S_IDLE, S_EXEC, S_RD_WAIT, S_RET, S_CON,
        S_STR_RD, S_STR_WAIT, S_STR_OUT, S_HALTED
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP, OP_WR, OP_RD, OP_NUM, OP_CHR, OP_STR,
        OP_ACT, OP_CLR, OP_VWR, OP_SIN, OP_COS
    } op_e;

    state_e state_q, state_d;
    op_e    op_q;

    logic [DATA_W-1:0] code_in, arg0_in, arg1_in;
    logic [DATA_W-1:0] arg0_q, arg1_q, load_q, con_data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              con_num_q;
    logic              sys_q;
    logic              accept;
    logic              limit_hit;

    assign code_in = sysregs[DATA_W-1:0];
    assign arg0_in = sysregs[2*DATA_W-1:DATA_W];
    assign arg1_in = sysregs[3*DATA_W-1:2*DATA_W];

    // Only a fresh rising edge of sys_signal in IDLE starts a syscall;
    // anything arriving while busy or halted is simply dropped.
    assign accept = (state_q == S_IDLE) && sys_signal && !sys_q;

    function automatic op_e decode_op(input logic [DATA_W-1:0] code);
        case (code)
            DATA_W'(1):  decode_op = OP_WR;
            DATA_W'(2):  decode_op = OP_RD;
            DATA_W'(3):  decode_op = OP_NUM;
            DATA_W'(4):  decode_op = OP_CHR;
            DATA_W'(5):  decode_op = OP_STR;
            DATA_W'(6):  decode_op = OP_ACT;
            DATA_W'(7):  decode_op = OP_CLR;
            DATA_W'(8):  decode_op = OP_VWR;
            DATA_W'(9):  decode_op = OP_SIN;
            DATA_W'(10): decode_op = OP_COS;
            default:     decode_op = OP_NOP;
        endcase
    endfunction

`ifdef SYSCALL_STRLEN_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_STR + 1);
    logic [CNT_W-1:0] cnt_q;
    // cnt_q counts characters already emitted, so the beat being accepted
    // now is the last one when cnt_q reaches MAX_STR-1.
    assign limit_hit = (cnt_q == CNT_W'(MAX_STR - 1));
`else
    logic unused_max_str;
    assign unused_max_str = ^MAX_STR;
    assign limit_hit      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (code_in == '0) ? S_HALTED : S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_RD, OP_SIN, OP_COS: state_d = S_RD_WAIT;
                    OP_NUM, OP_CHR:        state_d = S_CON;
                    OP_STR:                state_d = S_STR_RD;
                    default:               state_d = S_IDLE;
                endcase
            end
            S_RD_WAIT:  state_d = S_RET;
            S_RET:      state_d = S_IDLE;
            S_CON:      if (con_ready) state_d = S_IDLE;
            S_STR_RD:   state_d = S_STR_WAIT;
            S_STR_WAIT: state_d = (mem_rdata == '0) ? S_IDLE : S_STR_OUT;
            S_STR_OUT: begin
                if (con_ready) begin
                    state_d = limit_hit ? S_IDLE : S_STR_RD;
                end
            end
            S_HALTED:   state_d = S_HALTED;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output decode: strobes come straight from state and latched op, which
    // keeps them mutually exclusive by construction.
    always_comb begin
        busy         = 1'b0;
        halt         = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        load_signal  = 1'b0;
        con_valid    = 1'b0;
        vid_activate = 1'b0;
        vid_clear    = 1'b0;
        vid_write    = 1'b0;
        case (state_q)
            S_IDLE:   ;
            S_HALTED: halt = 1'b1;
            S_EXEC: begin
                busy         = 1'b1;
                mem_we       = (op_q == OP_WR);
                mem_re       = (op_q == OP_RD);
                vid_activate = (op_q == OP_ACT);
                vid_clear    = (op_q == OP_CLR);
                vid_write    = (op_q == OP_VWR);
            end
            S_RET: begin
                busy        = 1'b1;
                load_signal = 1'b1;
            end
            S_CON, S_STR_OUT: begin
                busy      = 1'b1;
                con_valid = 1'b1;
            end
            S_STR_RD: begin
                busy   = 1'b1;
                mem_re = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (clear) begin
            sys_q      <= 1'b0;
            op_q       <= OP_NOP;
            arg0_q     <= '0;
            arg1_q     <= '0;
            addr_q     <= '0;
            load_q     <= '0;
            con_data_q <= '0;
            con_num_q  <= 1'b0;
`ifdef SYSCALL_STRLEN_LIMIT_EN
            cnt_q      <= '0;
`endif
        end else begin
            sys_q <= sys_signal;
            if (accept) begin
                op_q   <= decode_op(code_in);
                arg0_q <= arg0_in;
                arg1_q <= arg1_in;
                addr_q <= ADDR_W'(arg0_in);
`ifdef SYSCALL_STRLEN_LIMIT_EN
                cnt_q  <= '0;
`endif
            end
            case (state_q)
                S_EXEC: begin
                    if (op_q == OP_NUM || op_q == OP_CHR) begin
                        con_data_q <= arg0_q;
                        con_num_q  <= (op_q == OP_NUM);
                    end
                end
                S_RD_WAIT: begin
                    load_q <= (op_q == OP_SIN || op_q == OP_COS) ? trig_rdata : mem_rdata;
                end
                S_STR_WAIT: begin
                    con_data_q <= mem_rdata;
                    con_num_q  <= 1'b0;
                end
                S_STR_OUT: begin
                    if (con_ready) begin
                        addr_q <= addr_q + ADDR_W'(1);
`ifdef SYSCALL_STRLEN_LIMIT_EN
                        cnt_q  <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = arg1_q;
    assign load_data  = load_q;
    assign con_data   = con_data_q;
    assign con_is_num = con_num_q;
    assign vid_addr   = arg0_q;
    assign vid_data   = arg1_q;
    // sin at even, cos at odd entry of the pair selected by arg0
    assign trig_addr  = TRIG_AW'({arg0_q, (op_q == OP_COS)});

endmodule

// File: tb/tb_syscall_unit.sv
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        clear;
    logic        sys_signal;
    logic [47:0] sysregs;
    logic        busy, halt;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic        load_signal;
    logic [15:0] load_data;
    logic [9:0]  trig_addr;
    logic [15:0] trig_rdata;
    logic        con_valid, con_ready, con_is_num;
    logic [15:0] con_data;
    logic        vid_activate, vid_clear, vid_write;
    logic [15:0] vid_addr, vid_data;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_load[$];
    logic [15:0] exp_con[$];
    logic [15:0] mem [0:65535];

    always #5 clk = ~clk;

    syscall_unit #(
        .DATA_W (16),
        .ADDR_W (16),
        .TRIG_AW(10),
        .MAX_STR(4)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .sys_signal  (sys_signal),
        .sysregs     (sysregs),
        .busy        (busy),
        .halt        (halt),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .load_signal (load_signal),
        .load_data   (load_data),
        .trig_addr   (trig_addr),
        .trig_rdata  (trig_rdata),
        .con_valid   (con_valid),
        .con_ready   (con_ready),
        .con_data    (con_data),
        .con_is_num  (con_is_num),
        .vid_activate(vid_activate),
        .vid_clear   (vid_clear),
        .vid_write   (vid_write),
        .vid_addr    (vid_addr),
        .vid_data    (vid_data)
    );

    function automatic logic [15:0] trig_val(input logic [9:0] a);
        return (16'(a) * 16'd7) ^ 16'h1234;
    endfunction

    // Environment: memory and trig table, both with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
        trig_rdata <= trig_val(trig_addr);
    end

    function automatic logic [8:0] strobes();
        return {busy, halt, mem_we, mem_re, load_signal, con_valid,
                vid_activate, vid_clear, vid_write};
    endfunction

    // Drives one request; returns at the negedge one cycle after acceptance.
    task automatic issue(input logic [15:0] code, input logic [15:0] a0, input logic [15:0] a1);
        sysregs    = {a1, a0, code};
        sys_signal = 1'b1;
        @(negedge clk);
        sys_signal = 1'b0;
    endtask

    task automatic test_reset();
        clear      = 1'b1;
        sys_signal = 1'b0;
        con_ready  = 1'b0;
        sysregs    = '0;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        tests++; if (strobes() !== 9'b0) begin fails++; $display("FAIL reset_strobes: got %b expected %b", strobes(), 9'b0); end
        tests++; if (mem_addr !== 16'h0) begin fails++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        tests++; if (load_data !== 16'h0) begin fails++; $display("FAIL reset_load_data: got %h expected 0000", load_data); end
        tests++; if (con_data !== 16'h0) begin fails++; $display("FAIL reset_con_data: got %h expected 0000", con_data); end
        tests++; if (trig_addr !== 10'h0) begin fails++; $display("FAIL reset_trig_addr: got %h expected 000", trig_addr); end
        @(negedge clk);
    endtask

    task automatic test_mem_rw();
        int pulses;
        logic [15:0] e;
        issue(16'd1, 16'h0040, 16'hBEEF);
        tests++; if ({mem_we, busy} !== 2'b11) begin fails++; $display("FAIL wr_strobe: got %b expected 11", {mem_we, busy}); end
        tests++; if (mem_addr !== 16'h0040) begin fails++; $display("FAIL wr_addr: got %h expected 0040", mem_addr); end
        tests++; if (mem_wdata !== 16'hBEEF) begin fails++; $display("FAIL wr_data: got %h expected beef", mem_wdata); end
        @(negedge clk);
        tests++; if ({mem_we, busy} !== 2'b00) begin fails++; $display("FAIL wr_end: got %b expected 00", {mem_we, busy}); end

        exp_load.push_back(16'hBEEF);
        issue(16'd2, 16'h0040, 16'h0000);
        pulses = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc == 1) begin
                tests++; if (mem_re !== 1'b1) begin fails++; $display("FAIL rd_strobe: got %b expected 1", mem_re); end
            end
            if (load_signal) begin
                pulses++;
                tests++; if (cyc != 3) begin fails++; $display("FAIL rd_latency: got cycle %0d expected 3", cyc); end
                if (exp_load.size() == 0) begin
                    tests++; fails++; $display("FAIL rd_extra_load: got %h expected none", load_data);
                end else begin
                    e = exp_load.pop_front();
                    tests++; if (load_data !== e) begin fails++; $display("FAIL rd_data: got %h expected %h", load_data, e); end
                end
            end
            @(negedge clk);
        end
        tests++; if (pulses != 1) begin fails++; $display("FAIL rd_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_num();
        int beats = 0;
        logic [15:0] e;
        con_ready = 1'b1;
        exp_con.push_back(16'hFFFB);
        issue(16'd3, 16'hFFFB, 16'h0000);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (con_valid && con_ready) begin
                beats++;
                tests++; if (con_is_num !== 1'b1) begin fails++; $display("FAIL num_flag: got %b expected 1", con_is_num); end
                if (exp_con.size() != 0) begin
                    e = exp_con.pop_front();
                    tests++; if (con_data !== e) begin fails++; $display("FAIL num_data: got %h expected %h", con_data, e); end
                end
            end
            @(negedge clk);
        end
        tests++; if (beats != 1) begin fails++; $display("FAIL num_beats: got %0d expected 1", beats); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL num_busy: got %b expected 0", busy); end
    endtask

    task automatic test_string_stall();
        int beats = 0, reads = 0;
        bit held = 0, done = 0;
        logic [15:0] held_data, e;
        mem[16'h0100] = 16'h0048; mem[16'h0101] = 16'h0069;
        mem[16'h0102] = 16'h0021; mem[16'h0103] = 16'h0000;
        exp_con.push_back(16'h0048); exp_con.push_back(16'h0069); exp_con.push_back(16'h0021);
        con_ready = 1'b0;
        issue(16'd5, 16'h0100, 16'h0000);
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            con_ready = (cyc % 2 == 1);
            if (mem_re) reads++;
            if (held) begin
                tests++; if (!con_valid || con_data !== held_data) begin fails++; $display("FAIL str_stable: got %b/%h expected 1/%h", con_valid, con_data, held_data); end
            end
            held = 0;
            if (con_valid) begin
                if (con_ready) begin
                    beats++;
                    if (exp_con.size() == 0) begin
                        tests++; fails++; $display("FAIL str_extra: got %h expected none", con_data);
                    end else begin
                        e = exp_con.pop_front();
                        tests++; if (con_data !== e) begin fails++; $display("FAIL str_char: got %h expected %h", con_data, e); end
                    end
                end else begin
                    held = 1; held_data = con_data;
                end
            end
            if (cyc > 1 && !busy) done = 1;
            @(negedge clk);
        end
        con_ready = 1'b0;
        tests++; if (!done) begin fails++; $display("FAIL str_timeout: got busy %b expected 0", busy); end
        tests++; if (beats != 3) begin fails++; $display("FAIL str_beats: got %0d expected 3", beats); end
        tests++; if (reads != 4) begin fails++; $display("FAIL str_reads: got %0d expected 4", reads); end
        exp_con.delete();
    endtask

    task automatic test_trig();
        int pulses;
        logic [9:0]  ea;
        logic [15:0] e;
        for (int k = 0; k < 2; k++) begin
            ea = 10'd90 + 10'(k);
            exp_load.push_back(trig_val(ea));
            issue(16'd9 + 16'(k), 16'd45, 16'h0000);
            pulses = 0;
            for (int cyc = 1; cyc <= 8; cyc++) begin
                if (cyc == 1) begin
                    tests++; if (trig_addr !== ea) begin fails++; $display("FAIL trig_addr: got %0d expected %0d", trig_addr, ea); end
                end
                if (load_signal) begin
                    pulses++;
                    tests++; if (cyc != 3) begin fails++; $display("FAIL trig_latency: got cycle %0d expected 3", cyc); end
                    if (exp_load.size() != 0) begin
                        e = exp_load.pop_front();
                        tests++; if (load_data !== e) begin fails++; $display("FAIL trig_data: got %h expected %h", load_data, e); end
                    end
                end
                @(negedge clk);
            end
            tests++; if (pulses != 1) begin fails++; $display("FAIL trig_pulses: got %0d expected 1", pulses); end
        end
    endtask

    task automatic test_video_misc();
        issue(16'd8, 16'h0012, 16'h0034);
        tests++; if (strobes() !== 9'b1_0000_0001) begin fails++; $display("FAIL vwr_strobe: got %b expected 100000001", strobes()); end
        tests++; if ({vid_addr, vid_data} !== {16'h0012, 16'h0034}) begin fails++; $display("FAIL vwr_cell: got %h/%h expected 0012/0034", vid_addr, vid_data); end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL vwr_busy: got %b expected 0", busy); end
        issue(16'd6, 16'h0000, 16'h0000);
        tests++; if (strobes() !== 9'b1_0000_0100) begin fails++; $display("FAIL vact_strobe: got %b expected 100000100", strobes()); end
        @(negedge clk);
        issue(16'd7, 16'h0000, 16'h0000);
        tests++; if (strobes() !== 9'b1_0000_0010) begin fails++; $display("FAIL vclr_strobe: got %b expected 100000010", strobes()); end
        @(negedge clk);
        issue(16'd11, 16'h0000, 16'h0000);
        tests++; if (strobes() !== 9'b1_0000_0000) begin fails++; $display("FAIL nop_strobe: got %b expected 100000000", strobes()); end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nop_busy: got %b expected 0", busy); end
    endtask

    task automatic test_clear_mid_string();
        int beats = 0;
        logic [15:0] e;
        for (int i = 0; i < 6; i++) mem[16'h0200 + 16'(i)] = 16'h0041 + 16'(i);
        mem[16'h0206] = 16'h0000;
        exp_con.push_back(16'h0041); exp_con.push_back(16'h0042);
        con_ready = 1'b1;
        issue(16'd5, 16'h0200, 16'h0000);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (con_valid && con_ready) begin
                beats++;
                e = exp_con.pop_front();
                tests++; if (con_data !== e) begin fails++; $display("FAIL clr_char: got %h expected %h", con_data, e); end
                if (beats == 2) break;
            end
            @(negedge clk);
        end
        tests++; if (beats != 2) begin fails++; $display("FAIL clr_beats: got %0d expected 2", beats); end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        tests++; if (strobes() !== 9'b0) begin fails++; $display("FAIL clr_strobes: got %b expected 000000000", strobes()); end
        tests++; if ({mem_addr, con_data} !== 32'h0) begin fails++; $display("FAIL clr_data: got %h/%h expected 0000/0000", mem_addr, con_data); end

        beats = 0;
        exp_con.push_back(16'h0041);
        issue(16'd4, 16'h0041, 16'h0000);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (con_valid && con_ready) begin
                beats++;
                e = exp_con.pop_front();
                tests++; if ({con_is_num, con_data} !== {1'b0, e}) begin fails++; $display("FAIL chr_beat: got %b/%h expected 0/%h", con_is_num, con_data, e); end
            end
            @(negedge clk);
        end
        tests++; if (beats != 1) begin fails++; $display("FAIL chr_beats: got %0d expected 1", beats); end
    endtask

    task automatic test_strlen();
`ifdef SYSCALL_STRLEN_LIMIT_EN
        int exp_beats = 4, exp_reads = 4;
`else
        int exp_beats = 10, exp_reads = 11;
`endif
        int beats = 0, reads = 0;
        bit done = 0;
        logic [15:0] e;
        for (int i = 0; i < 10; i++) mem[16'h0300 + 16'(i)] = 16'h0030 + 16'(i);
        mem[16'h030A] = 16'h0000;
        for (int i = 0; i < exp_beats; i++) exp_con.push_back(16'h0030 + 16'(i));
        con_ready = 1'b1;
        issue(16'd5, 16'h0300, 16'h0000);
        for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
            if (mem_re) reads++;
            if (con_valid && con_ready) begin
                beats++;
                if (exp_con.size() != 0) begin
                    e = exp_con.pop_front();
                    tests++; if (con_data !== e) begin fails++; $display("FAIL len_char: got %h expected %h", con_data, e); end
                end
            end
            if (cyc > 1 && !busy) done = 1;
            @(negedge clk);
        end
        tests++; if (!done) begin fails++; $display("FAIL len_timeout: got busy %b expected 0", busy); end
        tests++; if (beats != exp_beats) begin fails++; $display("FAIL len_beats: got %0d expected %0d", beats, exp_beats); end
        tests++; if (reads != exp_reads) begin fails++; $display("FAIL len_reads: got %0d expected %0d", reads, exp_reads); end
        exp_con.delete();
    endtask

    task automatic test_halt();
        bit saw = 0;
        issue(16'd0, 16'h0000, 16'h0000);
        tests++; if (halt !== 1'b1) begin fails++; $display("FAIL halt_set: got %b expected 1", halt); end
        @(negedge clk);
        issue(16'd6, 16'h0000, 16'h0000);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            if (vid_activate || busy) saw = 1;
            @(negedge clk);
        end
        tests++; if (saw) begin fails++; $display("FAIL halt_ignore: got activity 1 expected 0"); end
        tests++; if (halt !== 1'b1) begin fails++; $display("FAIL halt_sticky: got %b expected 1", halt); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        tests++; if (halt !== 1'b0) begin fails++; $display("FAIL halt_clear: got %b expected 0", halt); end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem_rdata  = '0;
        trig_rdata = '0;
        @(negedge clk);
        test_reset();
        test_mem_rw();
        test_num();
        test_string_stall();
        test_trig();
        test_video_misc();
        test_clear_mid_string();
        test_strlen();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

endmodule
